// File: rtl/zktc_artys7_soc.sv
// Arty S7 UART loopback self-test: transmits a fixed pattern on txd, receives it on rxd
// through an interrupt path, and reports pass (1010) or fail (0101) on the LEDs.
module zktc_artys7_soc #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       txd,
  output logic [3:0] led,
  output logic       io0,
  output logic       io1,
  output logic       io2,
  output logic       io3,
  output logic       io4,
  output logic       io5,
  output logic       io6,
  output logic       io7
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_IRQ, S_CHECK, S_PASS, S_FAIL} seq_state_t;

  function automatic logic [7:0] pattern_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h55;
      2'd1:    return 8'hAA;
      2'd2:    return 8'h0F;
      default: return 8'hF0;
    endcase
  endfunction

  // ---------------- transmitter ----------------
  logic          tx_start, tx_busy, txd_r;
  logic [7:0]    tx_data;
  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bitn <= '0;
      txd_r   <= 1'b1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, tx_data, 1'b0};
        tx_cnt  <= '0;
        tx_bitn <= '0;
        txd_r   <= 1'b0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      txd_r  <= tx_sh[1];
      if (tx_bitn == 4'd9) tx_busy <= 1'b0;
      else                 tx_bitn <= tx_bitn + 4'd1;
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_prev, rx_busy, rx_valid, rx_ferr;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bitn;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk) begin
    if (rstn) begin
      // NOTE: synchronizer resets to idle-high so releasing reset never looks like a start edge.
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_cnt   <= '0;
      rx_bitn  <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bitn <= '0;
        end
      end else if (rx_bitn == 4'd0) begin
        // Mid-start re-check: a high line here means the edge was a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bitn <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == BIT_LAST) begin
        rx_cnt <= '0;
        if (rx_bitn == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_s2;
          rx_ferr  <= ~rx_s2;
        end else begin
          rx_sh   <= {rx_s2, rx_sh[7:1]};
          rx_bitn <= rx_bitn + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // ---------------- interrupt controller ----------------
  logic       irq_pending, irq_enable, irq_ferr, irq_ack, irq_en_set;
  logic [7:0] irq_data;

  always_ff @(posedge clk) begin
    if (rstn) begin
      irq_pending <= 1'b0;
      irq_enable  <= 1'b0;
      irq_ferr    <= 1'b0;
      irq_data    <= '0;
    end else begin
      // A new event wins over a simultaneous acknowledge.
      if (rx_valid || rx_ferr) begin
        irq_pending <= 1'b1;
        irq_ferr    <= rx_ferr;
        irq_data    <= rx_sh;
      end else if (irq_ack) begin
        irq_pending <= 1'b0;
      end
      if (irq_en_set)   irq_enable <= 1'b1;
      else if (irq_ack) irq_enable <= 1'b0;
    end
  end

  // ---------------- sequencer ----------------
  seq_state_t    state, state_n;
  logic [1:0]    idx, idx_n;
  logic [TW-1:0] tmo;
  logic [3:0]    led_r, led_n;
  logic [7:0]    io_r;
  logic          io_we;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= S_IDLE;
      idx   <= '0;
      tmo   <= '0;
      led_r <= '0;
      io_r  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      led_r <= led_n;
      if (state == S_SEND)          tmo <= '0;
      else if (state == S_WAIT_IRQ) tmo <= tmo + TW'(1);
      if (io_we) io_r <= irq_data;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tx_start   = 1'b0;
    tx_data    = pattern_byte(idx);
    irq_en_set = 1'b0;
    irq_ack    = 1'b0;
    io_we      = 1'b0;
    case (state)
      S_IDLE: state_n = S_SEND;
      S_SEND: begin
        tx_start   = 1'b1;
        irq_en_set = 1'b1;
        state_n    = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (irq_pending && irq_enable) state_n = S_CHECK;
        else if (tmo == TMO_LAST)      state_n = S_FAIL;
      end
      S_CHECK: begin
        irq_ack = 1'b1;
        io_we   = 1'b1;
        if (irq_ferr || irq_data != pattern_byte(idx)) state_n = S_FAIL;
        else if (idx == 2'd3)                          state_n = S_PASS;
        else if (!tx_busy) begin
          idx_n   = idx + 2'd1;
          state_n = S_SEND;
        end
      end
      default: ;
    endcase
    led_n = {2'b00, idx_n};
    if (state_n == S_PASS)      led_n = 4'b1010;
    else if (state_n == S_FAIL) led_n = 4'b0101;
  end

  assign txd = txd_r;
  assign led = led_r;
  assign {io7, io6, io5, io4, io3, io2, io1, io0} = io_r;

endmodule

// File: tb/tb_zktc_artys7_soc.sv
// Directed bench for zktc_artys7_soc: loopback pass, open loop, corrupted byte,
// framing error, glitch rejection and reset in mid-frame.
`timescale 1ns/1ps
module tb_zktc_artys7_soc;

  localparam int CPB = 16;
  localparam int TMO = 20 * CPB;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       rxd;
  logic       txd;
  logic [3:0] led;
  logic       io0, io1, io2, io3, io4, io5, io6, io7;

  logic        open_loop = 1'b0, use_delay = 1'b0, force_low = 1'b0, force_high = 1'b0;
  logic [63:0] hist = '1;
  int          checks = 0, errors = 0;
  logic [11:0] trace[$];
  int          overlap, busy_cycles, starts;

  // {led, io} sequences expected from the sequencer; the first CHECK of each byte lands
  // while the stop bit is still being sent, so io updates one step before led advances.
  localparam logic [11:0] LOOP_TRACE [8] =
    '{12'h000, 12'h055, 12'h155, 12'h1AA, 12'h2AA, 12'h20F, 12'h30F, 12'hAF0};
  localparam logic [11:0] CORRUPT_TRACE [4] = '{12'h000, 12'h055, 12'h155, 12'h5AB};
  localparam logic [11:0] FERR_TRACE [2]    = '{12'h000, 12'h555};

  wire [7:0] io = {io7, io6, io5, io4, io3, io2, io1, io0};

  always #5 clk = ~clk;
  always @(posedge clk) hist <= {hist[62:0], txd};

  assign rxd = open_loop ? 1'b1 :
               ((((use_delay ? hist[CPB-1] : txd) & ~force_low)) | force_high);

  zktc_artys7_soc #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd), .led(led),
    .io0(io0), .io1(io1), .io2(io2), .io3(io3),
    .io4(io4), .io5(io5), .io6(io6), .io7(io7)
  );

  task automatic pulse_reset();
    @(negedge clk) rstn = 1'b1;
    @(negedge clk) rstn = 1'b0;
  endtask

  task automatic wait_fall(input int budget, output bit ok);
    logic prev;
    int   n;
    prev = txd;
    ok   = 1'b0;
    n    = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (prev && !txd) ok = 1'b1;
      prev = txd;
    end
  endtask

  task automatic run_to_end(input int budget, output int cycles);
    logic [11:0] cur;
    trace.delete();
    overlap = 0; busy_cycles = 0; starts = 0;
    trace.push_back({led, io});
    cycles = 0;
    while (cycles < budget && led != 4'hA && led != 4'h5) begin
      @(negedge clk);
      cycles++;
      cur = {led, io};
      if (cur != trace[$]) trace.push_back(cur);
      if (dut.tx_start && dut.tx_busy) overlap++;
      if (dut.tx_start) starts++;
      if (dut.tx_busy) busy_cycles++;
    end
    if (led != 4'hA && led != 4'h5) cycles = -1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1)   begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (led !== 4'h0)   begin errors++; $display("FAIL reset_led: got %b expected 0000", led); end
    checks++; if (io !== 8'h00)   begin errors++; $display("FAIL reset_io: got %h expected 00", io); end
    rstn = 1'b0;
  endtask

  task automatic test_tx_frame();
    bit         ok;
    logic [9:0] frame;
    pulse_reset();
    wait_fall(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tx_start_edge: got none expected falling txd"); end
    repeat (CPB / 2) @(negedge clk);
    frame[0] = txd;
    for (int k = 1; k < 10; k++) begin
      repeat (CPB) @(negedge clk);
      frame[k] = txd;
    end
    checks++;
    if (frame !== 10'b1_0101_0101_0) begin
      errors++; $display("FAIL tx_frame_55: got %b expected 1010101010", frame);
    end
  endtask

  task automatic test_loopback();
    int cyc;
    bit ok, low_seen;
    pulse_reset();
    run_to_end(100000, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL loop_timeout: got no verdict expected 1010"); end
    checks++; if (led !== 4'hA) begin errors++; $display("FAIL loop_led: got %b expected 1010", led); end
    checks++; if (io !== 8'hF0) begin errors++; $display("FAIL loop_io: got %h expected f0", io); end
    ok = (trace.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (trace[i] !== LOOP_TRACE[i]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL loop_trace: got %p expected %p", trace, LOOP_TRACE); end
    low_seen = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (!txd) low_seen = 1'b1;
      if (dut.tx_busy) busy_cycles++;
      if (dut.tx_start) starts++;
    end
    checks++; if (low_seen) begin errors++; $display("FAIL pass_txd_idle: got low expected high"); end
    checks++; if (starts !== 4) begin errors++; $display("FAIL launches: got %0d expected 4", starts); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL back_to_back: got %0d overlaps expected 0", overlap); end
    checks++;
    if (busy_cycles !== 40 * CPB) begin
      errors++; $display("FAIL tx_busy_len: got %0d expected %0d", busy_cycles, 40 * CPB);
    end
  endtask

  task automatic test_open_loop();
    open_loop = 1'b1;
    pulse_reset();
    repeat (TMO - 10) @(negedge clk);
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL open_early_led: got %b expected 0000", led); end
    repeat (30) @(negedge clk);
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL open_led: got %b expected 0101", led); end
    checks++; if (io !== 8'h00) begin errors++; $display("FAIL open_io: got %h expected 00", io); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL open_txd: got %b expected 1", txd); end
    open_loop = 1'b0;
  endtask

  task automatic test_corrupt_byte();
    int cyc;
    bit ok1, ok2, ok;
    pulse_reset();
    fork
      run_to_end(20000, cyc);
      begin
        wait_fall(50, ok1);
        repeat (10 * CPB - 4) @(negedge clk);
        wait_fall(50, ok2);
        repeat (CPB) @(negedge clk);
        force_high = 1'b1;
        repeat (CPB) @(negedge clk);
        force_high = 1'b0;
      end
    join
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL corrupt_frames: got %b%b expected 11", ok1, ok2); end
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL corrupt_led: got %b expected 0101", led); end
    checks++; if (io !== 8'hAB) begin errors++; $display("FAIL corrupt_io: got %h expected ab", io); end
    ok = (trace.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (trace[i] !== CORRUPT_TRACE[i]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL corrupt_trace: got %p expected %p", trace, CORRUPT_TRACE); end
  endtask

  task automatic test_framing_error();
    int cyc;
    bit ok1, ok;
    pulse_reset();
    fork
      run_to_end(20000, cyc);
      begin
        wait_fall(50, ok1);
        repeat (9 * CPB) @(negedge clk);
        force_low = 1'b1;
        repeat (CPB) @(negedge clk);
        force_low = 1'b0;
      end
    join
    checks++; if (!ok1) begin errors++; $display("FAIL ferr_frame: got none expected falling txd"); end
    checks++; if (led !== 4'h5) begin errors++; $display("FAIL ferr_led: got %b expected 0101", led); end
    ok = (trace.size() == 2);
    for (int i = 0; i < 2 && ok; i++) if (trace[i] !== FERR_TRACE[i]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ferr_trace: got %p expected %p", trace, FERR_TRACE); end
  endtask

  task automatic test_glitch();
    int   cyc, rises, events;
    logic prev_busy;
    use_delay = 1'b1;
    pulse_reset();
    force_low = 1'b1;
    rises = 0; events = 0;
    prev_busy = dut.rx_busy;
    for (int i = 0; i < 3 * CPB; i++) begin
      if (i == CPB / 4) force_low = 1'b0;
      @(negedge clk);
      if (dut.rx_busy && !prev_busy) rises++;
      prev_busy = dut.rx_busy;
      if (dut.irq_pending || dut.rx_valid || dut.rx_ferr) events++;
    end
    checks++; if (events !== 0) begin errors++; $display("FAIL glitch_irq: got %0d events expected 0", events); end
    checks++; if (rises !== 2) begin errors++; $display("FAIL glitch_starts: got %0d expected 2", rises); end
    run_to_end(20000, cyc);
    checks++; if (led !== 4'hA) begin errors++; $display("FAIL glitch_led: got %b expected 1010", led); end
    checks++; if (io !== 8'hF0) begin errors++; $display("FAIL glitch_io: got %h expected f0", io); end
    use_delay = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int cyc, n;
    bit ok;
    pulse_reset();
    n = 0;
    while (led !== 4'h2 && n < 5000) begin @(negedge clk); n++; end
    checks++; if (led !== 4'h2) begin errors++; $display("FAIL mid_third_byte: got %b expected 0010", led); end
    repeat (3 * CPB) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_txd: got %b expected 1", txd); end
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL mid_led: got %b expected 0000", led); end
    checks++; if (io !== 8'h00) begin errors++; $display("FAIL mid_io: got %h expected 00", io); end
    run_to_end(20000, cyc);
    ok = (trace.size() == 8);
    for (int i = 0; i < 8 && ok; i++) if (trace[i] !== LOOP_TRACE[i]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL mid_restart_trace: got %p expected %p", trace, LOOP_TRACE); end
    checks++; if (led !== 4'hA) begin errors++; $display("FAIL mid_final_led: got %b expected 1010", led); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_open_loop();
    test_corrupt_byte();
    test_framing_error();
    test_glitch();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
